// File: rtl/uart_tx_frame_if.sv
// Host-side bundle for the UART transmit framer: word request in, serial line and Busy out.
interface uart_tx_frame_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop; one bit per clk.
module uart_tx_frame #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             RST,
    uart_tx_frame_if.slave   bus
);
    localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  tx_q;
    logic                  busy_q;

    // Parity is resolved at accept time so the PARITY cycle only replays a stored bit.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.Data_Valid && !busy_q) begin
                        data_q    <= bus.P_DATA;
                        par_en_q  <= bus.PAR_EN;
                        par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
                        cnt_q     <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    tx_q    <= data_q[0];
                    state_q <= DATA;
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        if (par_en_q) begin
                            tx_q    <= par_bit_q;
                            state_q <= PARITY;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        tx_q  <= data_q[cnt_q + CNT_W'(1)];
                    end
                end
                PARITY: begin
                    tx_q    <= 1'b1;
                    state_q <= STOP;
                end
                STOP: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit framer: the transmit-side counterpart of the RX sampling/check chain.
- Accepts a parallel word with a one-cycle valid strobe and serializes it LSB-first on TX_OUT.
- Frame: start bit, data bits, optional parity bit, stop bit.
- clk runs at the bit rate, so each TX bit lasts exactly one clk period. Sits between the host-side data source and the serial line.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
- clk  input  1  bit-rate clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel word to send; sampled only on an accepted Data_Valid.
- Data_Valid  input  1  single-cycle request strobe.
- PAR_EN  input  1  1 = insert parity bit; sampled with P_DATA.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled with P_DATA.
- TX_OUT  output  1  serial line, registered; idles high.
- Busy  output  1  registered; high while a frame is on the line.

Behaviour:
- Reset (RST=1, asynchronous, any time including mid-frame):
  - TX_OUT=1, Busy=0.
  - FSM goes to IDLE; bit counter and data/parity shadow registers are cleared.
  - The aborted frame is not resumed.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - Accept on a rising edge with Data_Valid=1 and Busy=0.
  - At that edge: latch P_DATA, PAR_EN and PAR_TYP into shadow registers, compute parity, go to START, drive TX_OUT<=0 and Busy<=1.
- START: one cycle. Next edge goes to DATA and drives shadow bit 0.
- DATA:
  - DATA_WIDTH cycles; bit counter 0..DATA_WIDTH-1 drives shadow bit [counter], LSB first.
  - After the last data bit: go to PARITY if latched PAR_EN=1, else go to STOP.
- PARITY: one cycle. TX_OUT = XOR of latched data, inverted when latched PAR_TYP=1.
- STOP:
  - One cycle, TX_OUT=1.
  - Next edge returns to IDLE and clears Busy (Busy<=0 at that edge).
- Timing:
  - Frame length N = DATA_WIDTH+2 (+1 if parity) cycles.
  - Busy is high for exactly N cycles, starting the edge after the accepting edge (the accepting edge itself sets Busy).
  - TX_OUT changes only on clk edges: no glitches, no combinational path from inputs to TX_OUT.
- Data_Valid while Busy=1: ignored. No queueing, no error flag.
- P_DATA, PAR_EN and PAR_TYP changing mid-frame: no effect (shadowed).
- Back-to-back frames:
  - Data_Valid may be asserted in the cycle Busy falls.
  - The minimum gap between frames is therefore one idle-high cycle after the stop bit. This is acceptable as extra stop time.
- Counter width: ceil(log2(DATA_WIDTH)) bits. It must not wrap inside DATA; compare against DATA_WIDTH-1.
- Data_Valid held high continuously: a new frame starts on every first edge where Busy=0. Each frame carries the P_DATA value present at its accept edge.

Test Plan:
- Reset check: assert RST mid-IDLE, then release -> TX_OUT=1, Busy=0. Data_Valid pulse during RST=1 -> no frame.
- DATA_WIDTH=8, PAR_EN=0, P_DATA=8'hA5, one-cycle Data_Valid:
  - TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1.
  - Busy high for exactly 10 cycles, then TX_OUT stays 1.
- P_DATA=8'hA5, PAR_EN=1:
  - PAR_TYP=0 -> parity bit 0, 11-cycle frame.
  - PAR_TYP=1 -> parity bit 1.
  - P_DATA=8'h01, PAR_TYP=0 -> parity bit 1.
- Mid-frame stimulus: change P_DATA to 8'hFF and pulse Data_Valid at data bit 3 of an 8'h00 frame -> frame stays all-zero data; no second frame starts.
- Back-to-back: Data_Valid held high with P_DATA=8'h3C then 8'hC3 -> two complete frames separated by exactly one idle-high cycle.
- Abort: assert RST during data bit 4 -> TX_OUT=1 and Busy=0 immediately (before next edge). After release, a fresh 8'h5A frame is transmitted correctly.
